// File: rtl/lopra_key_loader.sv
// -----------------------------------------------------------------------------
// lopra_key_loader
//
// Serial key loader and key register for the XOR-locked lower-part-OR adder.
// A key frame is KEY_W key bits (LSB first) followed by one even-parity bit,
// carried on valid-qualified serial cycles with arbitrary gaps. A clean frame
// commits atomically to key_o; a corrupt frame pulses err_o and leaves the
// committed key untouched. MAX_FAIL consecutive corrupt frames latch a
// lockout that forces the all-zero (locked) key until reset.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   load_start_i  one-cycle pulse opening (or restarting) a key frame
//   key_valid_i   key_bit_i carries a frame bit this cycle
//   key_bit_i     serial key / parity bit
//   key_o         committed key, drives the adder keyinput bus
//   key_ready_o   key_o holds a committed key
//   busy_o        a frame is in progress
//   err_o         one-cycle pulse on a parity failure
//   lockout_o     sticky lockout indication, cleared only by rst
// -----------------------------------------------------------------------------
module lopra_key_loader #(
    parameter int KEY_W    = 32,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start_i,
    input  logic             key_valid_i,
    input  logic             key_bit_i,
    output logic [KEY_W-1:0] key_o,
    output logic             key_ready_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             lockout_o
);

    // The counter only has to address key bits; the parity bit is tracked by
    // the PARITY state rather than by a counter value of KEY_W.
    localparam int CNT_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PARITY  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [KEY_W-1:0]  sh_q,      sh_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [FAIL_W-1:0] fail_q,    fail_d;
    logic              par_q,     par_d;
    logic [KEY_W-1:0]  key_q,     key_d;
    logic              ready_q,   ready_d;
    logic              busy_q,    busy_d;
    logic              err_q,     err_d;
    logic              lock_q,    lock_d;

    logic [FAIL_W-1:0] fail_inc_s;

    // Even parity: the running XOR of the key bits combined with the trailer
    // must be zero for the frame to be accepted.
    function automatic logic frame_parity_ok(input logic run_par, input logic par_bit);
        return (run_par ^ par_bit) == 1'b0;
    endfunction

    assign fail_inc_s = fail_q + FAIL_W'(1);

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        par_d   = par_q;
        key_d   = key_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        lock_d  = lock_q;

        case (state_q)
            ST_IDLE: begin
                // A valid bit arriving with the start pulse is not part of the frame.
                if (load_start_i) begin
                    state_d = ST_SHIFT;
                    sh_d    = {KEY_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    par_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT, ST_PARITY: begin
                if (load_start_i) begin
                    // Restart: drop the partial frame, keep the failure history.
                    state_d = ST_SHIFT;
                    sh_d    = {KEY_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    par_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (key_valid_i) begin
                    if (state_q == ST_SHIFT) begin
                        sh_d[cnt_q] = key_bit_i;
                        cnt_d       = cnt_q + CNT_W'(1);
                        par_d       = par_q ^ key_bit_i;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else if (frame_parity_ok(par_q, key_bit_i)) begin
                        state_d = ST_IDLE;
                        key_d   = sh_q;
                        ready_d = 1'b1;
                        fail_d  = {FAIL_W{1'b0}};
                        busy_d  = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_inc_s;
                        busy_d = 1'b0;
                        if (fail_inc_s >= FAIL_LIMIT) begin
                            // Lockout forces the adder back to its locked key.
                            state_d = ST_LOCKOUT;
                            key_d   = {KEY_W{1'b0}};
                            ready_d = 1'b0;
                            lock_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
                key_d   = {KEY_W{1'b0}};
                ready_d = 1'b0;
                busy_d  = 1'b0;
                lock_d  = 1'b1;
            end

            default: begin
                // Unreachable encoding: fall to the safe, locked configuration.
                state_d = ST_LOCKOUT;
                key_d   = {KEY_W{1'b0}};
                ready_d = 1'b0;
                busy_d  = 1'b0;
                lock_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= {KEY_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            fail_q  <= {FAIL_W{1'b0}};
            par_q   <= 1'b0;
            key_q   <= {KEY_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            par_q   <= par_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
        end
    end

    assign key_o       = key_q;
    assign key_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign lockout_o   = lock_q;

endmodule

// File: tb/tb_lopra_key_loader.sv
// -----------------------------------------------------------------------------
// tb_lopra_key_loader
//
// Randomized bench for lopra_key_loader. A frame-level model (list of received
// bits, commit/fail decision once KEY_W+1 bits are in) predicts every output
// after every clock edge; a single compare process checks all outputs each
// cycle. Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_lopra_key_loader;

    localparam int KEY_W    = 32;
    localparam int MAX_FAIL = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ls  = 1'b0;
    logic             kv  = 1'b0;
    logic             kb  = 1'b0;
    logic [KEY_W-1:0] key_o;
    logic             key_ready_o, busy_o, err_o, lockout_o;

    int vectors    = 0;
    int miscompares = 0;

    lopra_key_loader #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start_i (ls),
        .key_valid_i  (kv),
        .key_bit_i    (kb),
        .key_o        (key_o),
        .key_ready_o  (key_ready_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .lockout_o    (lockout_o)
    );

    always #5 clk = ~clk;

    // Inputs as seen by the DUT at each rising edge.
    logic c_rst, c_ls, c_kv, c_kb, c_seen = 1'b0;
    always @(posedge clk) begin
        c_rst  <= rst;
        c_ls   <= ls;
        c_kv   <= kv;
        c_kb   <= kb;
        c_seen <= 1'b1;
    end

    // Behavioural model state
    bit               m_in_frame = 0;
    bit               bits_q[$];
    logic [KEY_W-1:0] m_key   = '0;
    bit               m_ready = 0;
    bit               m_err   = 0;
    bit               m_lock  = 0;
    int               m_fails = 0;

    task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit x;
        logic [KEY_W-1:0] k;
        m_err = 0;
        if (c_rst) begin
            m_in_frame = 0; bits_q.delete();
            m_key = '0; m_ready = 0; m_lock = 0; m_fails = 0;
        end else if (m_lock) begin
            // everything ignored
        end else if (c_ls) begin
            m_in_frame = 1; bits_q.delete();
        end else if (m_in_frame && c_kv) begin
            bits_q.push_back(c_kb);
            if (bits_q.size() == KEY_W + 1) begin
                m_in_frame = 0;
                x = 0;
                foreach (bits_q[i]) x ^= bits_q[i];
                for (int i = 0; i < KEY_W; i++) k[i] = bits_q[i];
                if (x == 0) begin
                    m_key = k; m_ready = 1; m_fails = 0;
                end else begin
                    m_err = 1;
                    m_fails++;
                    if (m_fails >= MAX_FAIL) begin
                        m_lock = 1; m_key = '0; m_ready = 0;
                    end
                end
            end
        end
    endtask

    // Compare process: advance the model by one edge, then check every output.
    initial begin
        forever begin
            @(negedge clk);
            if (c_seen) begin
                model_step();
                chk("key_o",       key_o,                      m_key);
                chk("key_ready_o", {{(KEY_W-1){1'b0}}, key_ready_o}, {{(KEY_W-1){1'b0}}, m_ready});
                chk("busy_o",      {{(KEY_W-1){1'b0}}, busy_o},      {{(KEY_W-1){1'b0}}, m_in_frame});
                chk("err_o",       {{(KEY_W-1){1'b0}}, err_o},       {{(KEY_W-1){1'b0}}, m_err});
                chk("lockout_o",   {{(KEY_W-1){1'b0}}, lockout_o},   {{(KEY_W-1){1'b0}}, m_lock});
            end
        end
    end

    // Watchdog
    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got running, expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit l, input bit v, input bit b);
        @(negedge clk);
        ls = l; kv = v; kb = b;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1; ls = 1'b0; kv = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic gaps(input int pct);
        while ($urandom_range(99) < pct) cyc(1'b0, 1'b0, 1'($urandom));
    endtask

    task automatic send_bits(input logic [KEY_W-1:0] k, input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            gaps(pct);
            cyc(1'b0, 1'b1, k[i]);
        end
    endtask

    // Start (optionally with a valid bit alongside), key bits, parity, one idle cycle.
    task automatic send_frame(input logic [KEY_W-1:0] k, input bit par, input int pct, input bit start_valid);
        cyc(1'b1, start_valid, 1'($urandom));
        send_bits(k, KEY_W, pct);
        gaps(pct);
        cyc(1'b0, 1'b1, par);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    function automatic bit even_par(input logic [KEY_W-1:0] k);
        return ^k;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [KEY_W-1:0] rk;
        bit               bad;

        do_reset(3);
        chk("reset key_o", key_o, 32'h0000_0000);
        chk("reset lockout", {31'd0, lockout_o}, 32'd0);

        // Good frame, no gaps
        send_frame(32'hA5A5_F00F, 1'b0, 0, 1'b0);
        chk("good key", key_o, 32'hA5A5_F00F);
        chk("good ready", {31'd0, key_ready_o}, 32'd1);
        chk("good busy falls", {31'd0, busy_o}, 32'd0);

        // Same key, wrong parity
        do_reset(1);
        send_frame(32'hA5A5_F00F, 1'b1, 0, 1'b0);
        chk("bad err pulse", {31'd0, err_o}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("bad err one cycle", {31'd0, err_o}, 32'd0);
        chk("bad key stays", key_o, 32'h0000_0000);
        chk("bad ready stays", {31'd0, key_ready_o}, 32'd0);
        chk("bad no lockout", {31'd0, lockout_o}, 32'd0);

        // Commit, then three bad frames -> lockout
        do_reset(1);
        send_frame(32'hA5A5_F00F, 1'b0, 0, 1'b0);
        send_frame(32'hA5A5_F00F, 1'b1, 0, 1'b0);
        send_frame(32'hA5A5_F00F, 1'b1, 0, 1'b0);
        chk("two fails key held", key_o, 32'hA5A5_F00F);
        chk("two fails no lock", {31'd0, lockout_o}, 32'd0);
        send_frame(32'hA5A5_F00F, 1'b1, 0, 1'b0);
        chk("third fail lock", {31'd0, lockout_o}, 32'd1);
        chk("third fail key zero", key_o, 32'h0000_0000);
        send_frame(32'h1234_5678, 1'b1, 0, 1'b0);
        chk("locked ignores frame", key_o, 32'h0000_0000);
        chk("locked not busy", {31'd0, busy_o}, 32'd0);
        do_reset(1);
        chk("rst clears lock", {31'd0, lockout_o}, 32'd0);

        // Random gaps
        send_frame(32'hFFFF_FFFF, 1'b0, 50, 1'b0);
        chk("gapped key", key_o, 32'hFFFF_FFFF);

        // Restart after 10 bits, with a valid bit on the restart cycle
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(32'hDEAD_BEEF, 10, 0);
        send_frame(32'h0000_0001, 1'b1, 0, 1'b1);
        chk("restart key", key_o, 32'h0000_0001);
        chk("restart no err", {31'd0, err_o}, 32'd0);

        // Reset after 20 bits, then a normal frame
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(32'h5555_AAAA, 20, 0);
        do_reset(1);
        chk("midframe rst key", key_o, 32'h0000_0000);
        chk("midframe rst busy", {31'd0, busy_o}, 32'd0);
        send_frame(32'h0F0F_0101, even_par(32'h0F0F_0101), 0, 1'b0);
        chk("post rst key", key_o, 32'h0F0F_0101);

        // Randomized frames against the model
        for (int n = 0; n < 40; n++) begin
            if (m_lock || $urandom_range(99) < 4) do_reset(1);
            rk  = KEY_W'($urandom);
            bad = ($urandom_range(99) < 20);
            if ($urandom_range(99) < 15) begin
                cyc(1'b1, 1'($urandom), 1'($urandom));
                send_bits(KEY_W'($urandom), $urandom_range(KEY_W), 30);
            end
            send_frame(rk, even_par(rk) ^ bad, $urandom_range(60), 1'($urandom));
            repeat ($urandom_range(3)) cyc(1'b0, 1'($urandom), 1'($urandom));
        end

        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lopra_key_loader.md
# lopra_key_loader

Serial key loader and key register for the XOR-locked 16-bit lower-part-OR ripple-carry adder. It receives the 32-bit unlock key as a framed serial bitstream with an even-parity trailer. It commits the key only on a clean frame and drives the adder's `keyinput` bus from `key_o`. Repeated corrupt frames latch a lockout, which holds the adder in its locked, all-zero-key state until reset.

## Interface
- `KEY_W`, default 32: key width, equal to the adder `keyinput` width.
- `MAX_FAIL`, default 3: number of consecutive parity failures that triggers lockout.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `load_start_i`, input, 1: single-cycle pulse that opens a new key frame.
- `key_valid_i`, input, 1: `key_bit_i` is valid this cycle.
- `key_bit_i`, input, 1: serial key or parity bit.
- `key_o`, output, KEY_W: committed key; connects to the adder `keyinput`.
- `key_ready_o`, output, 1: `key_o` holds a committed key.
- `busy_o`, output, 1: a frame is in progress.
- `err_o`, output, 1: one-cycle pulse on a parity failure.
- `lockout_o`, output, 1: loader is locked out; sticky until `rst`.

## Operation
- Frame format: KEY_W key bits, LSB first (bit 0 = first valid bit), then 1 parity bit. A frame is good when the XOR of all KEY_W+1 bits is 0 (even parity).
- Only cycles with `key_valid_i`=1 count as bits. Gaps of any length are allowed.
- Internal state: shift register `sh[KEY_W-1:0]`, bit counter (0..KEY_W), failure counter (0..MAX_FAIL).
- State machine: IDLE, SHIFT, PARITY, LOCKOUT.
  - IDLE: `load_start_i`=1 moves to SHIFT, clears `sh` and the bit counter, and sets `busy_o`=1. `key_valid_i` is ignored in IDLE.
  - SHIFT: each valid bit is written to `sh[cnt]` and the counter increments. The valid bit with cnt=KEY_W-1 moves to PARITY.
  - PARITY: the next valid bit is the parity bit.
    - Pass: `key_o` <= `sh`, `key_ready_o`=1, failure counter cleared, go to IDLE.
    - Fail: `err_o` pulses, failure counter +1, `key_o` and `key_ready_o` unchanged, go to IDLE. If the counter reaches MAX_FAIL, go to LOCKOUT instead.
  - LOCKOUT: `key_o`=0, `key_ready_o`=0, `lockout_o`=1, `busy_o`=0. All inputs are ignored. Only `rst` exits LOCKOUT.
- `busy_o`=1 in SHIFT and PARITY only.
- During a reload, `key_o` and `key_ready_o` keep the previously committed key until the new frame commits. Downstream never sees a partial key.
- `load_start_i` in SHIFT or PARITY restarts the frame: `sh` and the counter are cleared, the state goes to SHIFT, and the failure counter is unchanged. A `key_valid_i` bit in the same cycle is discarded.
- `load_start_i` in IDLE together with `key_valid_i`: the frame opens and that bit is discarded.
- Parity is computed on the fly: a running XOR updates on each valid bit and is cleared at frame start.

## Timing
- Reset values: `key_o`=0, `key_ready_o`=0, `busy_o`=0, `err_o`=0, `lockout_o`=0, state IDLE, both counters 0.
- `rst` mid-frame aborts the frame and returns to the reset values on the next edge. The previously committed key is lost.
- Latencies:
  - `busy_o` rises 1 cycle after the `load_start_i` cycle.
  - `key_o`, `key_ready_o`, or `err_o` respond 1 cycle after the parity-bit cycle; `busy_o` falls on that same edge.
  - `lockout_o` rises on the same edge as the final `err_o` pulse.
- Minimum frame: 1 start cycle + KEY_W+1 valid cycles. The earliest commit is 34 cycles after start for KEY_W=32.
- Back-to-back: a new `load_start_i` is accepted in the cycle immediately after the commit edge.

## Test plan
- Good frame, key 0xA5A5F00F, parity 0, no gaps: 1 cycle after the parity bit, `key_o`=0xA5A5F00F and `key_ready_o`=1. The adder with this key on 0x0F0F+0x0101 matches the golden model.
- Same key with parity bit 1: `err_o` high for exactly 1 cycle, `key_o` stays 0, `key_ready_o` stays 0, `lockout_o`=0.
- Commit 0xA5A5F00F, then three bad frames:
  - `key_o` stays 0xA5A5F00F through the first two failures.
  - On the third failure, `lockout_o`=1 and `key_o`=0.
  - A following good frame of 0x12345678 (parity 1) is ignored.
  - `rst` clears everything.
- Random `key_valid_i` gaps (~50% duty) with key 0xFFFFFFFF, parity 0: commits 0xFFFFFFFF.
- Restart after 10 bits with a new `load_start_i` (and a valid bit in the same cycle), then a full frame of 0x00000001, parity 1: commits 0x00000001 with no error.
- Assert `rst` after 20 bits of a frame: next cycle all outputs are 0 and the state is IDLE; a subsequent good frame commits normally.
